counter_mod_falling: RTL

COUNTER_MOD_FALLING -- requirements
Module: counter_mod_falling

---
 rtl/counter_pkg.sv | 13 +
 rtl/reg_fall_sync.sv | 25 ++
 rtl/counter_mod_falling.sv | 85 ++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the modulus counters: saturate-mode encodings and a
// parameter sanity helper.
package counter_pkg;

    localparam int unsigned MODE_WRAP = 0;
    localparam int unsigned MODE_SAT  = 1;

    // True when modulus m fits a w-bit register and leaves at least two states.
    function automatic bit modulus_ok(input int unsigned w, input int unsigned m);
        return (m >= 2) && (longint'(m) <= (longint'(1) << w));
    endfunction

endpackage

// File: rtl/reg_fall_sync.sv
// WIDTH-bit register clocked on the falling edge, with enable and a synchronous
// clear that takes priority over the enable.
module reg_fall_sync #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;

    always_ff @(negedge clk_i) begin
        if (clr_i) begin
            q_q <= '0;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/counter_mod_falling.sv
// Up/down modulus counter updated on the falling clock edge, with parallel load,
// terminal-count pulse and a sticky boundary-crossing flag.
module counter_mod_falling
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH    = 5,
    parameter int unsigned MODULUS  = 32,
    parameter int unsigned SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             ovf
);

    if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
        $error("counter_mod_falling: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MaxVal  = WIDTH'(MODULUS - 1);
    localparam bit               SatMode = (SATURATE == MODE_SAT);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             crossing;

    always_comb begin
        count_d  = count_q;
        crossing = 1'b0;
        if (load) begin
            count_d = (load_val > MaxVal) ? MaxVal : load_val;
        end else if (en) begin
            if (up) begin
                if (count_q == MaxVal) begin
                    crossing = 1'b1;
                    count_d  = SatMode ? MaxVal : '0;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    crossing = 1'b1;
                    count_d  = SatMode ? '0 : MaxVal;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
        tc_d  = crossing;
        // A fresh crossing wins over a simultaneous clear request.
        ovf_d = crossing | (ovf_q & ~clr_ovf);
    end

    reg_fall_sync #(
        .WIDTH(WIDTH)
    ) u_count_reg (
        .clk_i(clk),
        .clr_i(rst),
        .en_i (load | en),
        .d_i  (count_d),
        .q_o  (count_q)
    );

    always_ff @(negedge clk) begin
        if (rst) begin
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign out = count_q;
    assign tc  = tc_q;
    assign ovf = ovf_q;

endmodule
